// File: rtl/ariane_pkg.sv
// Minimal core-wide parameters shared with the divider path.
package ariane_pkg;
    localparam int TRANS_ID_BITS = 3;
endpackage

// File: rtl/serdiv_pkg.sv
// Types shared between the divider issue queue and serdiv_wrapper.
package serdiv_pkg;
    typedef enum logic [1:0] {
        UDIV = 2'd0,
        DIV  = 2'd1,
        UREM = 2'd2,
        REM  = 2'd3
    } div_opcode_e;

    typedef struct packed {
        logic op_a;
        logic op_b;
    } div_label_t;
endpackage

// File: rtl/div_issue_queue.sv
// In-order request FIFO in front of the serial divider; the divider-side valid
// comes only from registered occupancy, so no in_vld/in_rdy loop can form.
module div_issue_queue
    import ariane_pkg::*;
    import serdiv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         req_vld_i,
    output logic                         req_rdy_o,
    input  logic [TRANS_ID_BITS-1:0]     req_id_i,
    input  logic [WIDTH-1:0]             req_op_a_i,
    input  logic [WIDTH-1:0]             req_op_b_i,
    input  logic [1:0]                   req_opcode_i,
    input  logic                         req_op_a_label_i,
    input  logic                         req_op_b_label_i,
    output logic                         div_vld_o,
    input  logic                         div_rdy_i,
    output logic [TRANS_ID_BITS-1:0]     div_id_o,
    output logic [WIDTH-1:0]             div_op_a_o,
    output logic [WIDTH-1:0]             div_op_b_o,
    output logic [1:0]                   div_opcode_o,
    output logic                         div_op_a_label_o,
    output logic                         div_op_b_label_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [WIDTH-1:0]         op_a;
        logic [WIDTH-1:0]         op_b;
        div_opcode_e              opcode;
        div_label_t               label;
    } entry_t;

    // Idle/empty image: zero payload, labels tainted.
    localparam entry_t IDLE_ENTRY = '{
        id: '0, op_a: '0, op_b: '0, opcode: UDIV,
        label: '{op_a: 1'b1, op_b: 1'b1}
    };

    entry_t         r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_full;

    entry_t         w_wr_entry;
    entry_t         w_head;
    logic           w_enq;
    logic           w_deq;
    logic [CW-1:0]  w_count_next;

    assign req_rdy_o    = !r_full;
    assign div_vld_o    = (r_count != '0);
    assign w_enq        = req_vld_i && !r_full && !flush_i;
    assign w_deq        = div_vld_o && div_rdy_i && !flush_i;
    assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

    assign w_wr_entry = '{
        id: req_id_i, op_a: req_op_a_i, op_b: req_op_b_i,
        opcode: div_opcode_e'(req_opcode_i),
        label: '{op_a: req_op_a_label_i, op_b: req_op_b_label_i}
    };

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= IDLE_ENTRY;
            end
        end else if (w_enq) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // Full is held set during reset so the producer is refused until the first edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b1;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

    assign w_head = div_vld_o ? r_mem[r_rd_ptr] : IDLE_ENTRY;

    assign div_id_o         = w_head.id;
    assign div_op_a_o       = w_head.op_a;
    assign div_op_b_o       = w_head.op_b;
    assign div_opcode_o     = w_head.opcode;
    assign div_op_a_label_o = w_head.label.op_a;
    assign div_op_b_label_o = w_head.label.op_b;
    assign count_o          = r_count;
endmodule

// File: tb/tb_div_issue_queue.sv
// Directed and random checks of div_issue_queue against a queue-based model.
module tb_div_issue_queue;
    import ariane_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [WIDTH-1:0]         a;
        logic [WIDTH-1:0]         b;
        logic [1:0]               op;
        logic                     la;
        logic                     lb;
    } txn_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     flush = 1'b0;
    logic                     req_vld = 1'b0;
    logic                     req_rdy;
    logic [TRANS_ID_BITS-1:0] req_id = '0;
    logic [WIDTH-1:0]         req_a = '0;
    logic [WIDTH-1:0]         req_b = '0;
    logic [1:0]               req_op = '0;
    logic                     req_la = 1'b0;
    logic                     req_lb = 1'b0;
    logic                     div_vld;
    logic                     div_rdy = 1'b0;
    logic [TRANS_ID_BITS-1:0] div_id;
    logic [WIDTH-1:0]         div_a;
    logic [WIDTH-1:0]         div_b;
    logic [1:0]               div_op;
    logic                     div_la;
    logic                     div_lb;
    logic [CW-1:0]            count;

    txn_t model_q[$];
    bit   m_rdy = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_id_i(req_id),
        .req_op_a_i(req_a), .req_op_b_i(req_b), .req_opcode_i(req_op),
        .req_op_a_label_i(req_la), .req_op_b_label_i(req_lb),
        .div_vld_o(div_vld), .div_rdy_i(div_rdy), .div_id_o(div_id),
        .div_op_a_o(div_a), .div_op_b_o(div_b), .div_opcode_o(div_op),
        .div_op_a_label_o(div_la), .div_op_b_label_o(div_lb),
        .count_o(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model: head of queue, or idle image when empty.
    task automatic check_outputs(input string tag);
        txn_t head;
        head = '{id: '0, a: '0, b: '0, op: '0, la: 1'b1, lb: 1'b1};
        if (model_q.size() != 0) head = model_q[0];
        chk({tag, ".vld"},   32'(div_vld), 32'(model_q.size() != 0));
        chk({tag, ".rdy"},   32'(req_rdy), 32'(m_rdy));
        chk({tag, ".count"}, 32'(count),   32'(model_q.size()));
        chk({tag, ".head"},  32'({div_id, div_a, div_b, div_op, div_la, div_lb}), 32'(head));
    endtask

    task automatic set_req(input bit v, input int id, input int a, input int b,
                           input int op, input bit la, input bit lb);
        req_vld = v;
        req_id  = TRANS_ID_BITS'(id);
        req_a   = WIDTH'(a);
        req_b   = WIDTH'(b);
        req_op  = 2'(op);
        req_la  = la;
        req_lb  = lb;
    endtask

    // One clock: model decides enq/deq from pre-edge state, then outputs are compared.
    task automatic cycle(input string tag);
        bit   enq, deq;
        txn_t t, d;
        enq = req_vld && m_rdy && !flush;
        deq = (model_q.size() != 0) && div_rdy && !flush;
        t   = '{id: req_id, a: req_a, b: req_b, op: req_op, la: req_la, lb: req_lb};
        @(posedge clk);
        if (flush) begin
            model_q.delete();
            $display("flush");
        end else begin
            if (deq) begin
                d = model_q.pop_front();
                $display("deq id=%0d a=%0h b=%0h op=%0d", d.id, d.a, d.b, d.op);
            end
            if (enq) begin
                model_q.push_back(t);
                $display("enq id=%0d a=%0h b=%0h op=%0d", t.id, t.a, t.b, t.op);
            end
        end
        m_rdy = (model_q.size() != DEPTH);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("reset");
        end
        rst = 1'b0;
        #1;
        chk("rdy_before_edge", 32'(req_rdy), 32'd0);
        cycle("post_reset");
        chk("rdy_after_edge", 32'(req_rdy), 32'd1);

        // Single pass with stalled divider
        set_req(1, 1, 'h20, 'h20, 0, 1'b1, 1'b0);
        cycle("sp_enq");
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("sp_id", 32'(div_id), 32'd1);
        chk("sp_la", 32'(div_la), 32'd1);
        chk("sp_lb", 32'(div_lb), 32'd0);
        for (int i = 0; i < 5; i++) cycle("sp_hold");
        chk("sp_hold_a", 32'(div_a), 32'h20);
        div_rdy = 1'b1;
        cycle("sp_deq");
        div_rdy = 1'b0;
        chk("sp_vld_low", 32'(div_vld), 32'd0);

        // Fill and order
        for (int i = 0; i < 5; i++) begin
            set_req(1, i, 16 * i + 1, i + 3, i % 4, i[0], ~i[0]);
            cycle("fill");
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_rdy", 32'(req_rdy), 32'd0);
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        div_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(div_id), 32'(i));
            cycle("drain");
        end
        chk("drain_empty", 32'(div_vld), 32'd0);

        // Simultaneous request and dequeue while full
        div_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, i + 4, i, i, 1, 1'b0, 1'b0);
            cycle("sim_fill");
        end
        set_req(1, 7, 'h77, 'h11, 3, 1'b1, 1'b1);
        div_rdy = 1'b1;
        cycle("sim_both");
        chk("sim_count", 32'(count), 32'd3);
        chk("sim_rdy", 32'(req_rdy), 32'd1);
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("sim_drain");

        // Streaming across pointer wrap
        div_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(1, i % 8, i * 7, 255 - i, i % 2, i[1], i[0]);
            cycle("wrap");
            chk("wrap_id", 32'(div_id), 32'(i % 8));
            chk("wrap_op", 32'(div_op), 32'(i % 2));
        end
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        cycle("wrap_tail");

        // Flush with three queued and one offered
        div_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1, i, i, i, 2, 1'b0, 1'b1);
            cycle("fl_fill");
        end
        set_req(1, 6, 'h66, 'h66, 1, 1'b0, 1'b0);
        flush = 1'b1;
        cycle("flush");
        flush = 1'b0;
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_vld", 32'(div_vld), 32'd0);
        cycle("flush_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                    $urandom, 1'($urandom), 1'($urandom));
            div_rdy = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        // Reset in the middle of traffic
        div_rdy = 1'b0;
        set_req(1, 3, 'h33, 'h44, 3, 1'b0, 1'b0);
        cycle("mid_fill");
        cycle("mid_fill");
        #2 rst = 1'b1;
        model_q.delete();
        m_rdy = 1'b0;
        #1 check_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 0, 0, 0, 0, 1'b0, 1'b0);
        check_outputs("mid_release");
        cycle("mid_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
